// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/compare plus iterative unsigned multiply and divide
// (one bit per cycle). The result and PSR flags are held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       psrWrite,
  output logic [4:0]       psrWrEn
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int M     = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDC = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBC = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;
  localparam logic [2:0] OP_MULU = 3'd5;
  localparam logic [2:0] OP_DIVU = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;      // multiplier / dividend, becomes product low / quotient
  logic [WIDTH-1:0]   b_q, b_d;      // multiplicand / divisor
  logic [WIDTH-1:0]   r_q, r_d;      // product high / partial remainder
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [4:0]         psr_write_q, psr_write_d;
  logic [4:0]         psr_wren_q, psr_wren_d;

  logic               accept;
  logic               cin;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   sc_res, sc_hi;
  logic [4:0]         sc_flags, sc_en;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, div_quo;

  assign out_valid = (state_q == S_DONE);
  assign in_ready  = (state_q == S_IDLE) || (out_valid && out_ready);
  assign accept    = in_valid && in_ready;

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign psrWrite  = psr_write_q;
  assign psrWrEn   = out_valid ? psr_wren_q : 5'b00000;

  // Single-cycle datapath works straight off the inputs so the result lands on accept.
  assign cin      = ((op == OP_ADDC) || (op == OP_SUBC)) && carry_in;
  assign add_sum  = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, cin};
  assign sub_diff = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, cin};
  assign add_ovf  = (dst[M] == src[M]) && (add_sum[M] != dst[M]);
  assign sub_ovf  = (dst[M] != src[M]) && (sub_diff[M] != dst[M]);

  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_flags = 5'b00000;
    sc_en    = 5'b00000;
    case (op)
      OP_ADD, OP_ADDC: begin
        sc_res   = add_sum[M:0];
        sc_flags = {add_sum[WIDTH], 1'b0, add_ovf, add_sum[M:0] == '0, add_sum[M]};
        sc_en    = 5'b10111;
      end
      OP_SUB, OP_SUBC: begin
        sc_res   = sub_diff[M:0];
        sc_flags = {sub_diff[WIDTH], 1'b0, sub_ovf, sub_diff[M:0] == '0, sub_diff[M]};
        sc_en    = 5'b10111;
      end
      OP_CMP: begin
        sc_res   = sub_diff[M:0];
        sc_flags = {1'b0, dst < src, 1'b0, sub_diff[M:0] == '0, $signed(dst) < $signed(src)};
        sc_en    = 5'b01011;
      end
      OP_DIVU: begin  // only reached with a zero divisor
        sc_res   = '1;
        sc_hi    = dst;
        sc_flags = 5'b00100;
        sc_en    = 5'b00110;
      end
      default: ;
    endcase
  end

  // Iteration steps: shift-add multiply (LSB first) and restoring divide (MSB first).
  assign mul_sum   = {1'b0, r_q} + ({1'b0, b_q} & {(WIDTH+1){a_q[0]}});
  assign mul_hi    = mul_sum[WIDTH:1];
  assign mul_lo    = {mul_sum[0], a_q[M:1]};
  assign div_shift = {r_q, a_q[M]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_rem   = div_ge ? div_diff[M:0] : div_shift[M:0];
  assign div_quo   = {a_q[M-1:0], div_ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    psr_write_d = psr_write_q;
    psr_wren_d  = psr_wren_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d = dst;
          b_d = src;
          r_d = '0;
          if (op == OP_MULU) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(WIDTH);
          end else if ((op == OP_DIVU) && (src != '0)) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d     = S_DONE;
            result_d    = sc_res;
            result_hi_d = sc_hi;
            psr_write_d = sc_flags;
            psr_wren_d  = sc_en;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        a_d   = mul_lo;
        r_d   = mul_hi;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          result_d    = mul_lo;
          result_hi_d = mul_hi;
          psr_write_d = {3'b000, {mul_hi, mul_lo} == '0, 1'b0};
          psr_wren_d  = 5'b00010;
        end
      end
      S_DIV: begin
        a_d   = div_quo;
        r_d   = div_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          result_d    = div_quo;
          result_hi_d = div_rem;
          psr_write_d = {3'b000, div_quo == '0, 1'b0};
          psr_wren_d  = 5'b00110;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      psr_write_q <= 5'b00000;
      psr_wren_q  <= 5'b00000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      psr_write_q <= psr_write_d;
      psr_wren_q  <= psr_wren_d;
    end
  end

endmodule
